// File: rtl/scsi_arb_pkg.sv
// Shared types and constants for the SCSI IC bus arbiter: state encoding,
// host DSACK_ encodings and counter widths.
package scsi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DMA     = 3'd1,
    CPU     = 3'd2,
    ACK     = 3'd3,
    BERR    = 3'd4,
    RECOVER = 3'd5
  } arb_state_t;

  localparam logic [1:0] DSACK_IDLE = 2'b11;
  localparam logic [1:0] DSACK_BYTE = 2'b10;

  localparam int BURST_CNT_W = 8;
  localparam int TO_CNT_W    = 10;

  // Burst counter saturates so a very long run never wraps back below the limit.
  function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] v);
    return (v == {BURST_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/scsi_sync_bit.sv
// Multi-flop synchroniser for one asynchronous active-low strobe; the chain
// resets to 1 so a strobe reads as inactive until genuinely sampled low.
module scsi_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {SYNC_STAGES{1'b1}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/scsi_bus_arbiter.sv
// Arbitrates the SCSI IC access state machine between host register cycles
// and DMA byte transfers, and terminates the host cycle with DSACK_ or BERR_.
module scsi_bus_arbiter
  import scsi_arb_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DMA_BURST_MAX = 8,
  parameter int CPU_TIMEOUT   = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cpusel_n,
  input  logic       i_as_n,
  input  logic       i_dreq_n,
  input  logic       i_dmaena,
  input  logic       i_sm_idle,
  input  logic       i_set_dsack,
  input  logic       i_dack,
  output logic       o_ccpureq,
  output logic       o_cdreq_n,
  output logic       o_cdsack_n,
  output logic [1:0] o_dsack_n,
  output logic       o_berr_n,
  output logic       o_dma_gnt
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(DMA_BURST_MAX);
  localparam logic [TO_CNT_W-1:0]    TO_LIMIT    = TO_CNT_W'(CPU_TIMEOUT);

  logic w_sel_s;
  logic w_as_s;
  logic w_dreq_s;
  logic w_cpu_pend;
  logic w_dack_rise;

  arb_state_t             r_state;
  arb_state_t             w_next_state;
  logic                   r_accepted;
  logic                   w_accepted_next;
  logic [TO_CNT_W-1:0]    r_to_cnt;
  logic [TO_CNT_W-1:0]    w_to_cnt_next;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  logic [BURST_CNT_W-1:0] w_burst_cnt_next;
  logic                   r_dack_q;

  logic       r_ccpureq;
  logic       r_cdreq_n;
  logic       r_cdsack_n;
  logic [1:0] r_dsack_n;
  logic       r_berr_n;
  logic       r_dma_gnt;
  logic       w_ccpureq_next;
  logic       w_cdreq_n_next;
  logic       w_cdsack_n_next;
  logic [1:0] w_dsack_n_next;
  logic       w_berr_n_next;
  logic       w_dma_gnt_next;

  scsi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_cpusel_n),
    .o_sync  (w_sel_s)
  );

  scsi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_as (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_as_n),
    .o_sync  (w_as_s)
  );

  scsi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dreq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_dreq_n),
    .o_sync  (w_dreq_s)
  );

  assign w_cpu_pend  = ~w_sel_s & ~w_as_s;
  assign w_dack_rise = i_dack & ~r_dack_q;

  always_comb begin
    w_next_state     = r_state;
    w_accepted_next  = r_accepted;
    w_to_cnt_next    = r_to_cnt;
    w_burst_cnt_next = r_burst_cnt;

    unique case (r_state)
      IDLE: begin
        w_accepted_next = 1'b0;
        w_to_cnt_next   = '0;
        if (w_cpu_pend && i_sm_idle) begin
          w_next_state = CPU;
        end else if (i_dmaena && !w_dreq_s && i_sm_idle) begin
          w_next_state     = DMA;
          w_burst_cnt_next = '0;
        end
      end

      // Pre-emption by a waiting host only once the burst allowance is used up.
      DMA: begin
        if (w_dack_rise) begin
          w_burst_cnt_next = sat_inc(r_burst_cnt);
        end
        if (i_sm_idle && (w_dreq_s || !i_dmaena ||
                          (w_cpu_pend && (r_burst_cnt >= BURST_LIMIT)))) begin
          w_next_state = IDLE;
        end
      end

      // The acceptance cycle itself counts as the first timeout cycle.
      CPU: begin
        if (r_accepted || !i_sm_idle) begin
          w_accepted_next = 1'b1;
          w_to_cnt_next   = r_to_cnt + 1'b1;
        end
        if (!r_accepted && i_sm_idle && w_as_s) begin
          w_next_state = IDLE;
        end else if (i_set_dsack) begin
          w_next_state = ACK;
        end else if (r_accepted && (r_to_cnt == TO_LIMIT)) begin
          w_next_state = BERR;
        end
      end

      ACK, BERR: begin
        if (w_as_s) begin
          w_next_state = RECOVER;
        end
      end

      RECOVER: begin
        if (i_sm_idle) begin
          w_next_state = IDLE;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_ccpureq_next  = (w_next_state == CPU) && !w_accepted_next;
    w_cdreq_n_next  = (w_next_state == DMA) ? w_dreq_s : 1'b1;
    w_dma_gnt_next  = (w_next_state == DMA);
    w_dsack_n_next  = (w_next_state == ACK) ? DSACK_BYTE : DSACK_IDLE;
    w_berr_n_next   = (w_next_state != BERR);
    w_cdsack_n_next = !((w_next_state == ACK) || (w_next_state == BERR));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_accepted  <= 1'b0;
      r_to_cnt    <= '0;
      r_burst_cnt <= '0;
      r_dack_q    <= 1'b0;
      r_ccpureq   <= 1'b0;
      r_cdreq_n   <= 1'b1;
      r_cdsack_n  <= 1'b1;
      r_dsack_n   <= DSACK_IDLE;
      r_berr_n    <= 1'b1;
      r_dma_gnt   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_accepted  <= w_accepted_next;
      r_to_cnt    <= w_to_cnt_next;
      r_burst_cnt <= w_burst_cnt_next;
      r_dack_q    <= i_dack;
      r_ccpureq   <= w_ccpureq_next;
      r_cdreq_n   <= w_cdreq_n_next;
      r_cdsack_n  <= w_cdsack_n_next;
      r_dsack_n   <= w_dsack_n_next;
      r_berr_n    <= w_berr_n_next;
      r_dma_gnt   <= w_dma_gnt_next;
    end
  end

  assign o_ccpureq  = r_ccpureq;
  assign o_cdreq_n  = r_cdreq_n;
  assign o_cdsack_n = r_cdsack_n;
  assign o_dsack_n  = r_dsack_n;
  assign o_berr_n   = r_berr_n;
  assign o_dma_gnt  = r_dma_gnt;

endmodule

// File: tb/tb_scsi_bus_arbiter.sv
// Self-checking bench for scsi_bus_arbiter: arbitration table, hand-written
// host/DMA sequences and randomised transactions with arithmetic expectations.
module tb_scsi_bus_arbiter;

  localparam int SYNC    = 2;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpusel_n = 1'b1;
  logic       as_n = 1'b1;
  logic       dreq_n = 1'b1;
  logic       dmaena = 1'b0;
  logic       sm_idle = 1'b1;
  logic       set_dsack = 1'b0;
  logic       dack = 1'b0;
  logic       ccpureq;
  logic       cdreq_n;
  logic       cdsack_n;
  logic [1:0] dsack_n;
  logic       berr_n;
  logic       dma_gnt;

  int checks = 0;
  int errors = 0;

  scsi_bus_arbiter #(
    .SYNC_STAGES   (SYNC),
    .DMA_BURST_MAX (BURST),
    .CPU_TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cpusel_n  (cpusel_n),
    .i_as_n      (as_n),
    .i_dreq_n    (dreq_n),
    .i_dmaena    (dmaena),
    .i_sm_idle   (sm_idle),
    .i_set_dsack (set_dsack),
    .i_dack      (dack),
    .o_ccpureq   (ccpureq),
    .o_cdreq_n   (cdreq_n),
    .o_cdsack_n  (cdsack_n),
    .o_dsack_n   (dsack_n),
    .o_berr_n    (berr_n),
    .o_dma_gnt   (dma_gnt)
  );

  always #5 clk = ~clk;

  // Stimulus bits: {cpusel_n, as_n, dreq_n, dmaena, sm_idle, set_dsack}
  // Expected bits: {ccpureq, dma_gnt, cdreq_n, dsack_n[1:0]}
  typedef struct {
    logic [5:0] stim;
    logic [4:0] expect_out;
    string      name;
  } vec_t;

  vec_t vecs[10];

  task automatic check1(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check2(input string name, input logic [1:0] actual, input logic [1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cpusel_n  = 1'b1;
    as_n      = 1'b1;
    dreq_n    = 1'b1;
    dmaena    = 1'b0;
    sm_idle   = 1'b1;
    set_dsack = 1'b0;
    dack      = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic applyStimulus(input logic [5:0] s);
    {cpusel_n, as_n, dreq_n, dmaena, sm_idle, set_dsack} = s;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] e);
    check1({name, ".ccpureq"}, ccpureq, e[4]);
    check1({name, ".dma_gnt"}, dma_gnt, e[3]);
    check1({name, ".cdreq_n"}, cdreq_n, e[2]);
    check2({name, ".dsack_n"}, dsack_n, e[1:0]);
  endtask

  task automatic checkResetValues(input string name);
    check1({name, ".ccpureq"},  ccpureq,  1'b0);
    check1({name, ".cdreq_n"},  cdreq_n,  1'b1);
    check1({name, ".cdsack_n"}, cdsack_n, 1'b1);
    check2({name, ".dsack_n"},  dsack_n,  2'b11);
    check1({name, ".berr_n"},   berr_n,   1'b1);
    check1({name, ".dma_gnt"},  dma_gnt,  1'b0);
  endtask

  // Host cycle: grant after accDelay cycles, SET_DSACK on edge ackEdge after
  // acceptance; beyond TIMEOUT edges the cycle must end in BERR_ instead.
  task automatic cpuTransaction(input int accDelay, input int ackEdge);
    bit expAck;
    bit term;
    expAck = (ackEdge <= TIMEOUT);
    cpusel_n = 1'b0;
    as_n     = 1'b0;
    sm_idle  = 1'b1;
    tick(SYNC);
    check1("cpu_req_early", ccpureq, 1'b0);
    tick(1);
    check1("cpu_req", ccpureq, 1'b1);
    repeat (accDelay) begin
      tick(1);
      check1("cpu_req_hold", ccpureq, 1'b1);
    end
    sm_idle = 1'b0;
    tick(1);
    check1("cpu_accept", ccpureq, 1'b0);
    for (int e = 1; e <= TIMEOUT + 2; e++) begin
      set_dsack = (e == ackEdge);
      tick(1);
      check2("cpu_dsack", dsack_n, (expAck && e >= ackEdge) ? 2'b10 : 2'b11);
      check1("cpu_berr", berr_n, (!expAck && e >= TIMEOUT) ? 1'b0 : 1'b1);
      term = (expAck && e >= ackEdge) || (!expAck && e >= TIMEOUT);
      check1("cpu_cdsack", cdsack_n, !term);
    end
    set_dsack = 1'b0;
    as_n      = 1'b1;
    cpusel_n  = 1'b1;
    tick(SYNC);
    check1("cpu_term_held", cdsack_n, 1'b0);
    tick(1);
    check2("cpu_release_dsack", dsack_n, 2'b11);
    check1("cpu_release_berr", berr_n, 1'b1);
    check1("cpu_release_cdsack", cdsack_n, 1'b1);
    tick(2);
    sm_idle = 1'b1;
    tick(2);
  endtask

  // DMA burst of nPulses bytes; with a host request waiting, DMA must yield
  // at the first idle point after exactly BURST acknowledges.
  task automatic dmaBurst(input int nPulses, input bit withCpu);
    bit exited;
    bit expGnt;
    dreq_n  = 1'b0;
    dmaena  = 1'b1;
    sm_idle = 1'b1;
    tick(SYNC + 1);
    check1("dma_enter_gnt", dma_gnt, 1'b1);
    check1("dma_enter_cdreq", cdreq_n, 1'b0);
    if (withCpu) begin
      cpusel_n = 1'b0;
      as_n     = 1'b0;
      tick(SYNC + 1);
      check1("dma_cpu_wait_gnt", dma_gnt, 1'b1);
    end
    exited = 1'b0;
    for (int k = 1; k <= nPulses && !exited; k++) begin
      sm_idle = 1'b0;
      dack    = 1'b1;
      tick(1);
      dack = 1'b0;
      tick(1);
      sm_idle = 1'b1;
      tick(1);
      expGnt = !(withCpu && k >= BURST);
      check1("dma_burst_gnt", dma_gnt, expGnt);
      check1("dma_burst_ccpureq", ccpureq, 1'b0);
      if (!expGnt) exited = 1'b1;
    end
    if (exited) begin
      tick(1);
      check1("dma_preempt_ccpureq", ccpureq, 1'b1);
      check1("dma_preempt_gnt", dma_gnt, 1'b0);
      dreq_n   = 1'b1;
      dmaena   = 1'b0;
      as_n     = 1'b1;
      cpusel_n = 1'b1;
      tick(SYNC + 1);
      check1("dma_cancel_ccpureq", ccpureq, 1'b0);
      check2("dma_cancel_dsack", dsack_n, 2'b11);
    end else begin
      sm_idle = 1'b0;
      tick(1);
      dmaena = 1'b0;
      tick(1);
      check1("dma_ena_drop_busy", dma_gnt, 1'b1);
      sm_idle = 1'b1;
      tick(1);
      check1("dma_ena_drop_exit", dma_gnt, 1'b0);
      dreq_n   = 1'b1;
      as_n     = 1'b1;
      cpusel_n = 1'b1;
      tick(SYNC + 2);
      check1("dma_end_ccpureq", ccpureq, 1'b0);
      check1("dma_end_gnt", dma_gnt, 1'b0);
    end
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{6'b111010, 5'b00111, "idle"};
    vecs[1] = '{6'b001010, 5'b10111, "cpu_req"};
    vecs[2] = '{6'b001000, 5'b00111, "cpu_sm_busy"};
    vecs[3] = '{6'b110110, 5'b01011, "dma_req"};
    vecs[4] = '{6'b110010, 5'b00111, "dreq_no_ena"};
    vecs[5] = '{6'b000110, 5'b10111, "tie_cpu_wins"};
    vecs[6] = '{6'b110100, 5'b00111, "dma_sm_busy"};
    vecs[7] = '{6'b100110, 5'b01011, "sel_only_dma"};
    vecs[8] = '{6'b011010, 5'b00111, "as_only"};
    vecs[9] = '{6'b111011, 5'b00111, "set_dsack_idle"};

    doReset();
    checkResetValues("after_reset");

    for (int i = 0; i < 10; i++) begin
      doReset();
      applyStimulus(vecs[i].stim);
      tick(SYNC + 2);
      checkOutput(vecs[i].name, vecs[i].expect_out);
    end

    // Asynchronous reset in the middle of a DMA byte.
    doReset();
    dreq_n = 1'b0;
    dmaena = 1'b1;
    tick(SYNC + 1);
    check1("rst_pre_gnt", dma_gnt, 1'b1);
    sm_idle = 1'b0;
    dack    = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    dack = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check1("rst_release_gnt", dma_gnt, 1'b0);
    check2("rst_release_dsack", dsack_n, 2'b11);
    doReset();

    // Cancel before acceptance, then prove the arbiter is back in IDLE.
    cpusel_n = 1'b0;
    as_n     = 1'b0;
    tick(SYNC + 1);
    check1("cancel_req", ccpureq, 1'b1);
    as_n     = 1'b1;
    cpusel_n = 1'b1;
    tick(SYNC);
    check1("cancel_req_hold", ccpureq, 1'b1);
    tick(1);
    check1("cancel_ccpureq", ccpureq, 1'b0);
    check2("cancel_dsack", dsack_n, 2'b11);
    check1("cancel_cdsack", cdsack_n, 1'b1);
    dreq_n = 1'b0;
    dmaena = 1'b1;
    tick(SYNC + 1);
    check1("cancel_then_dma", dma_gnt, 1'b1);
    doReset();

    // AS_ already released when SET_DSACK arrives: ACK lasts one cycle.
    cpusel_n = 1'b0;
    as_n     = 1'b0;
    tick(SYNC + 1);
    sm_idle = 1'b0;
    tick(1);
    as_n     = 1'b1;
    cpusel_n = 1'b1;
    tick(SYNC + 1);
    check1("late_as_no_cancel", cdsack_n, 1'b1);
    set_dsack = 1'b1;
    tick(1);
    set_dsack = 1'b0;
    check2("short_ack_dsack", dsack_n, 2'b10);
    check1("short_ack_cdsack", cdsack_n, 1'b0);
    tick(1);
    check2("short_ack_end", dsack_n, 2'b11);
    check1("short_ack_cdsack_end", cdsack_n, 1'b1);
    sm_idle = 1'b1;
    tick(2);

    cpuTransaction(1, 3);
    cpuTransaction(0, TIMEOUT + 5);
    cpuTransaction(2, TIMEOUT);
    dmaBurst(12, 1'b1);
    dmaBurst(20, 1'b0);
    dmaBurst(3, 1'b1);

    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 1) == 0) begin
        cpuTransaction(int'($urandom_range(0, 4)), int'($urandom_range(1, TIMEOUT + 4)));
      end else begin
        dmaBurst(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
